decode_stage_p: RTL

Parametrised, pipelined successor to the CPU decode stage. It holds the architectural register file (2 read ports, 1 write port, optional write-through bypass) and performs immediate extension, operand forwarding and branch-target calculation. It also detects load-use hazards and inserts one-cycle bubbles. Results are registered into an ID/EX pipeline register with valid/ready backpressure and flush; it sits between fetch and execute.

---
 rtl/decode_pkg.sv | 43 ++++
 rtl/regfile_bypass.sv | 60 ++++++
 rtl/decode_stage_p.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/decode_pkg.sv
// decode_pkg: shared definitions for the decode stage.
//   - instruction field bit positions (rs / rt / rd)
//   - immediate-select and destination-select encodings
//   - default link register index
//   - srcHits(): one operand's load-use match term for hazard detection
package decode_pkg;

    localparam int INSTR_W = 16;
    localparam int REG_AW  = 3;

    localparam int RS_MSB = 10;
    localparam int RS_LSB = 8;
    localparam int RT_MSB = 7;
    localparam int RT_LSB = 5;
    localparam int RD_MSB = 4;
    localparam int RD_LSB = 2;

    localparam logic [REG_AW-1:0] LINK_REG_DEFAULT = 3'd7;

    // Immediate extension selector (ctl_sext_sel)
    typedef enum logic [1:0] {
        IMM_SEXT5  = 2'b00,
        IMM_SEXT8  = 2'b01,
        IMM_SEXT11 = 2'b10,
        IMM_ZEXT   = 2'b11
    } imm_sel_e;

    // Destination register selector (ctl_wr_sel)
    typedef enum logic [1:0] {
        DEST_RT   = 2'b00,
        DEST_RD   = 2'b01,
        DEST_RS   = 2'b10,
        DEST_LINK = 2'b11
    } dest_sel_e;

    // True when an operand that is actually read matches the in-flight load destination
    function automatic logic srcHits(input logic uses,
                                     input logic [REG_AW-1:0] src,
                                     input logic [REG_AW-1:0] dest);
        return uses && (src == dest);
    endfunction

endpackage

// File: rtl/regfile_bypass.sv
// regfile_bypass: NREG x DW architectural register file.
//   clk, rst            : clock, synchronous active-high clear of every entry
//   wrEn/wrAddr/wrData  : single write port, written on the rising edge
//   rdAddrA/rdDataA     : combinational read port A
//   rdAddrB/rdDataB     : combinational read port B
// With BYPASS=1 a read of the address being written this cycle returns wrData.
// Entry 0 is an ordinary register.
module regfile_bypass #(
    parameter int DW     = 16,
    parameter int NREG   = 8,
    parameter bit BYPASS = 1'b1,
    parameter int AW     = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wrEn,
    input  logic [AW-1:0] wrAddr,
    input  logic [DW-1:0] wrData,
    input  logic [AW-1:0] rdAddrA,
    output logic [DW-1:0] rdDataA,
    input  logic [AW-1:0] rdAddrB,
    output logic [DW-1:0] rdDataB
);

    logic [DW-1:0] mem_r [NREG];

    // Storage: clear on reset, otherwise single-port write
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem_r[i] <= {DW{1'b0}};
            end
        end else if (wrEn) begin
            mem_r[wrAddr] <= wrData;
        end else begin
            mem_r[wrAddr] <= mem_r[wrAddr];
        end
    end

    // Read port A with optional same-cycle write-through
    always_comb begin
        rdDataA = mem_r[rdAddrA];
        if (BYPASS && wrEn && (wrAddr == rdAddrA)) begin
            rdDataA = wrData;
        end else begin
            rdDataA = mem_r[rdAddrA];
        end
    end

    // Read port B with optional same-cycle write-through
    always_comb begin
        rdDataB = mem_r[rdAddrB];
        if (BYPASS && wrEn && (wrAddr == rdAddrB)) begin
            rdDataB = wrData;
        end else begin
            rdDataB = mem_r[rdAddrB];
        end
    end

endmodule

// File: rtl/decode_stage_p.sv
// decode_stage_p: pipelined decode stage between fetch and execute.
//   clk, rst                  : clock, synchronous active-high reset
//   if_valid/if_instr/if_next_pc, id_ready : fetch handshake
//   ctl_*                     : decoded control from the instruction decoder
//   wb_en/wb_addr/wb_data     : register-file write-back port
//   fwd_rs_*/fwd_rt_*         : operand forwarding overrides
//   id_target_pc, hazard_stall: combinational early branch target and load-use stall
//   ex_ready, flush           : execute backpressure and pipeline discard
//   ex_*                      : registered ID/EX pipeline register
module decode_stage_p
    import decode_pkg::*;
#(
    parameter int          DW       = 16,
    parameter int          NREG     = 8,
    parameter logic [2:0]  LINK_REG = LINK_REG_DEFAULT,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_valid,
    input  logic [15:0]   if_instr,
    input  logic [DW-1:0] if_next_pc,
    output logic          id_ready,
    input  logic          ex_ready,
    input  logic          flush,
    input  logic [1:0]    ctl_sext_sel,
    input  logic          ctl_zext8,
    input  logic          ctl_imm_op2,
    input  logic          ctl_load_link,
    input  logic          ctl_pc_base_sel,
    input  logic          ctl_branch_imm11,
    input  logic [1:0]    ctl_wr_sel,
    input  logic          ctl_uses_rs,
    input  logic          ctl_uses_rt,
    input  logic          ctl_reg_write,
    input  logic          ctl_is_load,
    input  logic          wb_en,
    input  logic [2:0]    wb_addr,
    input  logic [DW-1:0] wb_data,
    input  logic          fwd_rs_en,
    input  logic          fwd_rt_en,
    input  logic [DW-1:0] fwd_rs_data,
    input  logic [DW-1:0] fwd_rt_data,
    output logic [DW-1:0] id_target_pc,
    output logic          hazard_stall,
    output logic          ex_valid,
    output logic          ex_reg_write,
    output logic          ex_is_load,
    output logic [DW-1:0] ex_op1,
    output logic [DW-1:0] ex_op2,
    output logic [DW-1:0] ex_imm,
    output logic [DW-1:0] ex_rt_data,
    output logic [DW-1:0] ex_next_pc,
    output logic [DW-1:0] ex_target_pc,
    output logic [2:0]    ex_dest,
    output logic [15:0]   ex_instr
);

    logic [2:0]    rs_s, rt_s, rd_s;
    logic [DW-1:0] rfRs_s, rfRt_s;
    logic [DW-1:0] rsVal_s, rtVal_s;
    logic [DW-1:0] sext5_s, sext8_s, sext11_s;
    logic [DW-1:0] imm_s, op1_s, op2_s;
    logic [DW-1:0] tgtBase_s, tgtOff_s;
    logic [2:0]    dest_s;
    logic          hazard_s, advance_s;

    assign rs_s = if_instr[RS_MSB:RS_LSB];
    assign rt_s = if_instr[RT_MSB:RT_LSB];
    assign rd_s = if_instr[RD_MSB:RD_LSB];

    regfile_bypass #(
        .DW     (DW),
        .NREG   (NREG),
        .BYPASS (BYPASS)
    ) u_rf (
        .clk     (clk),
        .rst     (rst),
        .wrEn    (wb_en),
        .wrAddr  (wb_addr),
        .wrData  (wb_data),
        .rdAddrA (rs_s),
        .rdDataA (rfRs_s),
        .rdAddrB (rt_s),
        .rdDataB (rfRt_s)
    );

    assign sext5_s  = {{(DW-5){if_instr[4]}},   if_instr[4:0]};
    assign sext8_s  = {{(DW-8){if_instr[7]}},   if_instr[7:0]};
    assign sext11_s = {{(DW-11){if_instr[10]}}, if_instr[10:0]};

    // Operand values: forwarding overrides the register file
    always_comb begin
        rsVal_s = rfRs_s;
        rtVal_s = rfRt_s;
        if (fwd_rs_en) begin
            rsVal_s = fwd_rs_data;
        end else begin
            rsVal_s = rfRs_s;
        end
        if (fwd_rt_en) begin
            rtVal_s = fwd_rt_data;
        end else begin
            rtVal_s = rfRt_s;
        end
    end

    // Immediate extension
    always_comb begin
        imm_s = sext5_s;
        case (imm_sel_e'(ctl_sext_sel))
            IMM_SEXT5:  imm_s = sext5_s;
            IMM_SEXT8:  imm_s = sext8_s;
            IMM_SEXT11: imm_s = sext11_s;
            IMM_ZEXT: begin
                if (ctl_zext8) begin
                    imm_s = {{(DW-8){1'b0}}, if_instr[7:0]};
                end else begin
                    imm_s = {{(DW-4){1'b0}}, if_instr[3:0]};
                end
            end
            default:    imm_s = sext5_s;
        endcase
    end

    // Operand muxing and branch target (forwarded rs is the register base)
    always_comb begin
        op1_s     = rsVal_s;
        op2_s     = rtVal_s;
        tgtBase_s = rsVal_s;
        tgtOff_s  = sext8_s;
        if (ctl_load_link) begin
            op1_s = if_next_pc;
        end else begin
            op1_s = rsVal_s;
        end
        if (ctl_imm_op2) begin
            op2_s = imm_s;
        end else begin
            op2_s = rtVal_s;
        end
        if (ctl_pc_base_sel) begin
            tgtBase_s = if_next_pc;
        end else begin
            tgtBase_s = rsVal_s;
        end
        if (ctl_branch_imm11) begin
            tgtOff_s = sext11_s;
        end else begin
            tgtOff_s = sext8_s;
        end
    end

    assign id_target_pc = tgtBase_s + tgtOff_s;

    // Destination register select
    always_comb begin
        dest_s = rt_s;
        case (dest_sel_e'(ctl_wr_sel))
            DEST_RT:   dest_s = rt_s;
            DEST_RD:   dest_s = rd_s;
            DEST_RS:   dest_s = rs_s;
            DEST_LINK: dest_s = LINK_REG;
            default:   dest_s = rt_s;
        endcase
    end

    // Load-use hazard against the load currently held in ID/EX
    always_comb begin
        hazard_s = 1'b0;
        if (if_valid && ex_valid && ex_is_load && ex_reg_write) begin
            hazard_s = srcHits(ctl_uses_rs, rs_s, ex_dest) ||
                       srcHits(ctl_uses_rt, rt_s, ex_dest);
        end else begin
            hazard_s = 1'b0;
        end
    end

    assign hazard_stall = hazard_s;
    assign advance_s    = ex_ready || !ex_valid;

    // Fetch handshake; a flush always drains the slot so fetch may proceed
    always_comb begin
        id_ready = 1'b0;
        if (rst) begin
            id_ready = 1'b0;
        end else begin
            id_ready = flush || (advance_s && !hazard_s);
        end
    end

    // ID/EX register: reset > flush > bubble > advance > hold.
    // Invalidation clears only the qualifiers; the payload keeps its value.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_is_load   <= 1'b0;
            ex_op1       <= {DW{1'b0}};
            ex_op2       <= {DW{1'b0}};
            ex_imm       <= {DW{1'b0}};
            ex_rt_data   <= {DW{1'b0}};
            ex_next_pc   <= {DW{1'b0}};
            ex_target_pc <= {DW{1'b0}};
            ex_dest      <= 3'd0;
            ex_instr     <= 16'd0;
        end else if (flush || (advance_s && hazard_s)) begin
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_is_load   <= 1'b0;
        end else if (advance_s) begin
            if (if_valid) begin
                ex_valid     <= 1'b1;
                ex_reg_write <= ctl_reg_write;
                ex_is_load   <= ctl_is_load;
                ex_op1       <= op1_s;
                ex_op2       <= op2_s;
                ex_imm       <= imm_s;
                ex_rt_data   <= rtVal_s;
                ex_next_pc   <= if_next_pc;
                ex_target_pc <= id_target_pc;
                ex_dest      <= dest_s;
                ex_instr     <= if_instr;
            end else begin
                ex_valid     <= 1'b0;
                ex_reg_write <= 1'b0;
                ex_is_load   <= 1'b0;
            end
        end else begin
            ex_valid     <= ex_valid;
            ex_reg_write <= ex_reg_write;
            ex_is_load   <= ex_is_load;
        end
    end

endmodule
